// File: rtl/note_pkg.sv
// Shared constants and the saturating-add helper for the note-lane engine.
// Purely declarative; no logic.
package note_pkg;
  localparam int SCORE_W        = 16;
  localparam int COMBO_W        = 8;
  localparam int MISS_W         = 16;
  localparam int COMBO_BONUS    = 10;
  localparam int DEF_LANE_X0    = 128;
  localparam int DEF_LANE_PITCH = 128;
  localparam int DEF_NOTE_HW    = 5;
  localparam int DEF_NOTE_HH    = 20;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] max);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[15:0];
  endfunction
endpackage

// File: rtl/note_lane.sv
// One lane: slot array, spawn/hit/advance/miss next-state and combinational pixel match.
// State updates on the edge after the event; spawn into a full lane is dropped by the caller.
module note_lane
  import note_pkg::*;
#(
  parameter int SLOTS   = 8,
  parameter int YW      = 11,
  parameter int SPAWN_Y = 40,
  parameter int HIT_Y   = 440,
  parameter int TOL     = 5,
  parameter int MISS_Y  = 460,
  parameter int SPEED   = 1,
  parameter int LANE_X  = DEF_LANE_X0,
  parameter int NOTE_HW = DEF_NOTE_HW,
  parameter int NOTE_HH = DEF_NOTE_HH,
  parameter int CW      = $clog2(SLOTS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_tick_i,
  input  logic          spawn_i,
  input  logic          press_i,
  input  logic [YW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  output logic          free_o,
  output logic          hit_o,
  output logic          empty_press_o,
  output logic [CW-1:0] miss_cnt_o,
  output logic          pix_o
);
  localparam int PW     = YW + 1;
  localparam int WIN_LO = (HIT_Y > TOL) ? HIT_Y - TOL : 0;
  localparam int WIN_HI = HIT_Y + TOL;
  localparam int X_LO   = (LANE_X > NOTE_HW) ? LANE_X - NOTE_HW : 0;
  localparam int X_HI   = LANE_X + NOTE_HW;

  logic [SLOTS-1:0] valid_q, valid_d;
  logic [YW-1:0]    y_q   [SLOTS];
  logic [YW-1:0]    y_d   [SLOTS];
  logic [PW-1:0]    y_adv [SLOTS];
  logic [SLOTS-1:0] in_win, y_match, hit_sel, free_sel, miss_vec;
  logic             x_in;

  // Window and pixel tests widened by one bit so the lower bounds never wrap.
  always_comb begin
    in_win  = '0;
    y_match = '0;
    for (int s = 0; s < SLOTS; s++) begin
      in_win[s]  = valid_q[s] && ({1'b0, y_q[s]} >= PW'(WIN_LO)) && ({1'b0, y_q[s]} <= PW'(WIN_HI));
      y_match[s] = valid_q[s] && (({1'b0, y_i} + PW'(NOTE_HH)) >= {1'b0, y_q[s]})
                              && ({1'b0, y_i} <= ({1'b0, y_q[s]} + PW'(NOTE_HH)));
    end
  end

  assign x_in     = ({1'b0, x_i} >= PW'(X_LO)) && ({1'b0, x_i} <= PW'(X_HI));
  assign hit_sel  = press_i ? (in_win & (~in_win + SLOTS'(1))) : '0;
  assign free_sel = ~valid_q & (valid_q + SLOTS'(1));

  assign free_o        = |(~valid_q);
  assign hit_o         = |hit_sel;
  assign empty_press_o = press_i && !(|in_win);
  assign pix_o         = x_in && (|y_match);

  always_comb begin
    valid_d  = valid_q;
    miss_vec = '0;
    for (int s = 0; s < SLOTS; s++) begin
      y_adv[s] = {1'b0, y_q[s]} + PW'(SPEED);
      y_d[s]   = y_q[s];
      if (hit_sel[s]) begin
        valid_d[s] = 1'b0;
      end else if (frame_tick_i && valid_q[s]) begin
        if (y_adv[s] > PW'(MISS_Y)) begin
          valid_d[s]  = 1'b0;
          miss_vec[s] = 1'b1;
        end else begin
          y_d[s] = y_adv[s][YW-1:0];
        end
      end
      // The free slot was invalid this cycle, so it can never also be hit or advanced.
      if (spawn_i && free_sel[s]) begin
        valid_d[s] = 1'b1;
        y_d[s]     = YW'(SPAWN_Y);
      end
    end
  end

  always_comb begin
    miss_cnt_o = '0;
    for (int s = 0; s < SLOTS; s++) miss_cnt_o += CW'(miss_vec[s]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int s = 0; s < SLOTS; s++) y_q[s] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int s = 0; s < SLOTS; s++) y_q[s] <= y_d[s];
    end
  end
endmodule

// File: rtl/note_lane_engine.sv
// Rhythm-game note engine: LANES lanes of falling notes, hit judging, score/combo/miss, pixel query.
// Counters/pulses update one cycle after the event, pix_* one cycle after x/y; spawn_ready is combinational.
module note_lane_engine
  import note_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int SLOTS      = 8,
  parameter int YW         = 11,
  parameter int SPAWN_Y    = 40,
  parameter int HIT_Y      = 440,
  parameter int TOL        = 5,
  parameter int MISS_Y     = 460,
  parameter int SPEED      = 1,
  parameter int LANE_X0    = DEF_LANE_X0,
  parameter int LANE_PITCH = DEF_LANE_PITCH,
  parameter int NOTE_HW    = DEF_NOTE_HW,
  parameter int NOTE_HH    = DEF_NOTE_HH,
  localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               spawn_valid,
  input  logic [LW-1:0]      spawn_lane,
  output logic               spawn_ready,
  input  logic [LANES-1:0]   btn,
  input  logic [YW-1:0]      x,
  input  logic [YW-1:0]      y,
  output logic               pix_note,
  output logic [LW-1:0]      pix_lane,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [MISS_W-1:0]  miss_cnt,
  output logic               hit_pulse,
  output logic               miss_pulse
);
  localparam int CW = $clog2(SLOTS + 1);
  localparam int NP = 1 << LW;

  logic [LANES-1:0]   btn_q, rise, free_v, hit_v, empty_v, pix_v;
  logic [CW-1:0]      lane_miss [LANES];
  logic [NP-1:0]      free_pad;
  logic [15:0]        hit_n, miss_n, bonus, combo_sum;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               hit_pulse_q, miss_pulse_q, pix_note_q;
  logic [LW-1:0]      pix_lane_q, pix_lane_d;

  assign rise        = btn & ~btn_q;
  assign free_pad    = NP'(free_v);
  assign spawn_ready = free_pad[spawn_lane];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    note_lane #(
      .SLOTS(SLOTS), .YW(YW), .SPAWN_Y(SPAWN_Y), .HIT_Y(HIT_Y), .TOL(TOL),
      .MISS_Y(MISS_Y), .SPEED(SPEED), .LANE_X(LANE_X0 + g * LANE_PITCH),
      .NOTE_HW(NOTE_HW), .NOTE_HH(NOTE_HH), .CW(CW)
    ) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_tick_i (frame_tick),
      .spawn_i      (spawn_valid && spawn_ready && (spawn_lane == LW'(g))),
      .press_i      (rise[g]),
      .x_i          (x),
      .y_i          (y),
      .free_o       (free_v[g]),
      .hit_o        (hit_v[g]),
      .empty_press_o(empty_v[g]),
      .miss_cnt_o   (lane_miss[g]),
      .pix_o        (pix_v[g])
    );
  end

  always_comb begin
    hit_n      = '0;
    miss_n     = '0;
    pix_lane_d = '0;
    for (int l = 0; l < LANES; l++) begin
      hit_n  += 16'(hit_v[l]);
      miss_n += 16'(lane_miss[l]);
    end
    for (int l = LANES - 1; l >= 0; l--) if (pix_v[l]) pix_lane_d = LW'(l);
  end

  // Bonus is judged on the combo held before this cycle's hits are added.
  assign bonus     = (combo_q >= COMBO_W'(COMBO_BONUS)) ? hit_n : '0;
  assign score_d   = sat_add(score_q, hit_n + bonus, 16'hFFFF);
  assign combo_sum = sat_add(16'(combo_q), hit_n, 16'((1 << COMBO_W) - 1));
  assign combo_d   = ((|empty_v) || (miss_n != '0)) ? '0 : combo_sum[COMBO_W-1:0];
  assign miss_d    = sat_add(miss_q, miss_n, 16'hFFFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q        <= '0;
      score_q      <= '0;
      combo_q      <= '0;
      miss_q       <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      pix_note_q   <= 1'b0;
      pix_lane_q   <= '0;
    end else begin
      btn_q        <= btn;
      score_q      <= score_d;
      combo_q      <= combo_d;
      miss_q       <= miss_d;
      hit_pulse_q  <= (hit_n != '0);
      miss_pulse_q <= (miss_n != '0);
      pix_note_q   <= |pix_v;
      pix_lane_q   <= pix_lane_d;
    end
  end

  assign score      = score_q;
  assign combo      = combo_q;
  assign miss_cnt   = miss_q;
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;
  assign pix_note   = pix_note_q;
  assign pix_lane   = pix_lane_q;
endmodule
